// File: rtl/bus_pkg.sv
// Shared types for the bus master: transaction bundle, FSM states, parity.
package bus_pkg;

    localparam int DATA_BUS_WIDTH = 32;
    localparam int ADDR_BUS_WIDTH = 8;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    typedef struct packed {
        logic                      rw;
        logic [ADDR_BUS_WIDTH-1:0] addr;
        logic [DATA_BUS_WIDTH-1:0] data;
    } txn_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RESP,
        DRAIN
    } state_t;

    function automatic logic compute_parity(
        input logic [DATA_BUS_WIDTH-1:0] d
    );
        return ^d;
    endfunction

endpackage

// File: rtl/bus_txn_fifo.sv
// Request queue for the bus master; DEPTH must be a power of two.
module bus_txn_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  txn_t push_txn,
    input  logic pop,
    output txn_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    txn_t          mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_txn;
    end

endmodule

// File: rtl/bus_master_ctrl.sv
// Queued single-outstanding bus master with parity and ack handshake.
// Define BUS_MASTER_ACK_TIMEOUT_EN to abort WAIT_ACK after ACK_TIMEOUT.
module bus_master_ctrl
    import bus_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rw,
    input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
    input  logic [DATA_BUS_WIDTH-1:0] req_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_BUS_WIDTH-1:0] rsp_data,
    output logic                      rsp_perr,
    output logic                      rsp_timeout,
    output logic [ADDR_BUS_WIDTH-1:0] bus_address,
    output logic                      bus_rb,
    output logic                      bus_wb,
    output logic [DATA_BUS_WIDTH-1:0] bus_data_out,
    output logic                      bus_parity_out,
    output logic                      bus_data_oe,
    input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
    input  logic                      bus_parity_in,
    input  logic                      bus_ack
);

    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be >= 2");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be >= 1");
    end

    state_t state_q, state_n;
    txn_t   head;
    txn_t   req_txn;
    logic   full, empty, pop, rd_perr;

    logic [ADDR_BUS_WIDTH-1:0] addr_n;
    logic [DATA_BUS_WIDTH-1:0] dout_n, rdata_n;
    logic rb_n, wb_n, oe_n, par_n;
    logic rvalid_n, perr_n, to_n;

`ifdef BUS_MASTER_ACK_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_n;
    logic          to_q;

    assign rsp_timeout = to_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign req_ready = !full;
    assign req_txn   = '{rw: req_rw, addr: req_addr, data: req_data};
    assign rd_perr   = compute_parity(bus_data_in) != bus_parity_in;

    bus_txn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (req_valid),
        .push_txn (req_txn),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        state_n  = state_q;
        pop      = 1'b0;
        addr_n   = bus_address;
        rb_n     = bus_rb;
        wb_n     = bus_wb;
        oe_n     = bus_data_oe;
        dout_n   = bus_data_out;
        par_n    = bus_parity_out;
        rvalid_n = rsp_valid;
        rdata_n  = rsp_data;
        perr_n   = rsp_perr;
        to_n     = 1'b0;
`ifdef BUS_MASTER_ACK_TIMEOUT_EN
        to_n     = to_q;
        cnt_n    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    addr_n = head.addr;
                    rb_n   = (head.rw == READ);
                    wb_n   = (head.rw == WRITE);
                    oe_n   = (head.rw == WRITE);
                    if (head.rw == WRITE) begin
                        dout_n = head.data;
                        par_n  = compute_parity(head.data);
                    end
`ifdef BUS_MASTER_ACK_TIMEOUT_EN
                    cnt_n  = '0;
`endif
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus_ack) begin
                    rb_n     = 1'b0;
                    wb_n     = 1'b0;
                    oe_n     = 1'b0;
                    rvalid_n = 1'b1;
                    to_n     = 1'b0;
                    perr_n   = bus_rb && rd_perr;
                    rdata_n  = (bus_rb && !rd_perr) ?
                               bus_data_in : '0;
                    state_n  = RESP;
                end
`ifdef BUS_MASTER_ACK_TIMEOUT_EN
                else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    rb_n     = 1'b0;
                    wb_n     = 1'b0;
                    oe_n     = 1'b0;
                    rvalid_n = 1'b1;
                    to_n     = 1'b1;
                    perr_n   = 1'b0;
                    rdata_n  = '0;
                    state_n  = RESP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rvalid_n = 1'b0;
                    state_n  = bus_ack ? DRAIN : IDLE;
                end
            end
            // A lingering ack must fall before the next issue.
            DRAIN: begin
                if (!bus_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            bus_address    <= '0;
            bus_rb         <= 1'b0;
            bus_wb         <= 1'b0;
            bus_data_oe    <= 1'b0;
            bus_data_out   <= '0;
            bus_parity_out <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_perr       <= 1'b0;
        end else begin
            state_q        <= state_n;
            bus_address    <= addr_n;
            bus_rb         <= rb_n;
            bus_wb         <= wb_n;
            bus_data_oe    <= oe_n;
            bus_data_out   <= dout_n;
            bus_parity_out <= par_n;
            rsp_valid      <= rvalid_n;
            rsp_data       <= rdata_n;
            rsp_perr       <= perr_n;
        end
    end

`ifdef BUS_MASTER_ACK_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_n;
            to_q  <= to_n;
        end
    end
`else
    logic unused_to;
    assign unused_to = to_n;
`endif

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed self-checking bench for bus_master_ctrl.
module tb_bus_master_ctrl;
    import bus_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_rw;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_perr, rsp_timeout;
    logic [7:0]  bus_address;
    logic        bus_rb, bus_wb;
    logic [31:0] bus_data_out;
    logic        bus_parity_out, bus_data_oe;
    logic [31:0] bus_data_in;
    logic        bus_parity_in, bus_ack;

    logic        auto_ack, man_ack, man_par;
    logic [31:0] man_data, auto_d;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Auto slave: acks in the first strobe cycle, returns the address.
    assign auto_d        = 32'(bus_address);
    assign bus_ack       = auto_ack ? (bus_rb | bus_wb) : man_ack;
    assign bus_data_in   = auto_ack ? auto_d : man_data;
    assign bus_parity_in = auto_ack ? ^auto_d : man_par;

    bus_master_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rw         (req_rw),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_perr       (rsp_perr),
        .rsp_timeout    (rsp_timeout),
        .bus_address    (bus_address),
        .bus_rb         (bus_rb),
        .bus_wb         (bus_wb),
        .bus_data_out   (bus_data_out),
        .bus_parity_out (bus_parity_out),
        .bus_data_oe    (bus_data_oe),
        .bus_data_in    (bus_data_in),
        .bus_parity_in  (bus_parity_in),
        .bus_ack        (bus_ack)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic send(
        input logic       rw,
        input logic [7:0] a,
        input logic [31:0] d
    );
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_data  = d;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    initial begin
        int k;
        int cnt;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        auto_ack  = 1'b0;
        man_ack   = 1'b0;
        man_data  = '0;
        man_par   = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rb", bus_rb, 0);
        check("rst_wb", bus_wb, 0);
        check("rst_oe", bus_data_oe, 0);
        check("rst_addr", bus_address, 0);
        check("rst_req_ready", req_ready, 1);
        reset = 1'b0;

        // Write, ack in the second WAIT_ACK cycle
        rsp_ready = 1'b1;
        send(WRITE, 8'h01, 32'h1);
        @(negedge clock);
        check("wr_wb_c1", bus_wb, 1);
        check("wr_dout", bus_data_out, 32'h1);
        check("wr_par", bus_parity_out, 1);
        check("wr_oe", bus_data_oe, 1);
        check("wr_addr", bus_address, 8'h01);
        @(negedge clock);
        check("wr_wb_c2", bus_wb, 1);
        man_ack = 1'b1;
        @(negedge clock);
        check("wr_wb_drop", bus_wb, 0);
        check("wr_oe_drop", bus_data_oe, 0);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_data", rsp_data, 0);
        check("wr_rsp_perr", rsp_perr, 0);
        check("wr_addr_hold", bus_address, 8'h01);
        man_ack = 1'b0;
        @(negedge clock);
        check("wr_rsp_done", rsp_valid, 0);

        // Good-parity read
        send(READ, 8'h02, 32'h0);
        @(negedge clock);
        check("rd_rb", bus_rb, 1);
        check("rd_oe", bus_data_oe, 0);
        check("rd_addr", bus_address, 8'h02);
        man_ack  = 1'b1;
        man_data = 32'h3;
        man_par  = 1'b0;
        @(negedge clock);
        check("rd_rb_drop", bus_rb, 0);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_data", rsp_data, 32'h3);
        check("rd_rsp_perr", rsp_perr, 0);
        man_ack = 1'b0;
        @(negedge clock);

        // Bad-parity read
        send(READ, 8'h03, 32'h0);
        @(negedge clock);
        check("pe_rb", bus_rb, 1);
        man_ack  = 1'b1;
        man_data = 32'h7;
        man_par  = 1'b0;
        @(negedge clock);
        check("pe_rsp_valid", rsp_valid, 1);
        check("pe_rsp_perr", rsp_perr, 1);
        check("pe_rsp_data", rsp_data, 0);
        man_ack = 1'b0;
        @(negedge clock);

        // Fill the queue while the first response is held
        rsp_ready = 1'b0;
        auto_ack  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("fill_ready", req_ready, 1);
            req_valid = 1'b1;
            req_rw    = READ;
            req_addr  = 8'h10 + 8'(i);
            req_data  = '0;
            @(negedge clock);
        end
        req_valid = 1'b0;
        check("full_ready", req_ready, 0);
        check("full_rsp_valid", rsp_valid, 1);
        check("full_rsp_data", rsp_data, 32'h10);
        @(negedge clock);
        check("hold_ready", req_ready, 0);
        check("hold_rsp_data", rsp_data, 32'h10);
        rsp_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && k < 5; c++) begin
            if (rsp_valid) begin
                check("drain_data", rsp_data, 32'h10 + k);
                check("drain_perr", rsp_perr, 0);
                k++;
            end
            @(negedge clock);
        end
        check("drain_count", k, 5);
        auto_ack = 1'b0;
        @(negedge clock);

        // Ack held across RESP forces DRAIN
        send(WRITE, 8'h20, 32'h5);
        @(negedge clock);
        check("dr_wb", bus_wb, 1);
        check("dr_par", bus_parity_out, 0);
        man_ack   = 1'b1;
        req_valid = 1'b1;
        req_rw    = READ;
        req_addr  = 8'h21;
        @(negedge clock);
        req_valid = 1'b0;
        check("dr_rsp_valid", rsp_valid, 1);
        check("dr_wb_drop", bus_wb, 0);
        @(negedge clock);
        check("dr_hold1", bus_rb, 0);
        @(negedge clock);
        check("dr_hold2", bus_rb, 0);
        man_ack = 1'b0;
        @(negedge clock);
        check("dr_idle", bus_rb, 0);
        @(negedge clock);
        check("dr_next_rb", bus_rb, 1);
        check("dr_next_addr", bus_address, 8'h21);

        // Reset during WAIT_ACK with a request queued
        req_valid = 1'b1;
        req_rw    = WRITE;
        req_addr  = 8'h22;
        req_data  = 32'h9;
        @(negedge clock);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        check("mr_rb", bus_rb, 0);
        check("mr_wb", bus_wb, 0);
        check("mr_oe", bus_data_oe, 0);
        check("mr_rsp_valid", rsp_valid, 0);
        check("mr_addr", bus_address, 0);
        check("mr_ready", req_ready, 1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("mr_empty_rb", bus_rb, 0);
            check("mr_empty_wb", bus_wb, 0);
            check("mr_empty_rsp", rsp_valid, 0);
        end

`ifdef BUS_MASTER_ACK_TIMEOUT_EN
        send(WRITE, 8'h30, 32'hFF);
        @(negedge clock);
        cnt = 0;
        while (bus_wb && cnt < 40) begin
            cnt++;
            @(negedge clock);
        end
        check("to_cycles", cnt, 16);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_flag", rsp_timeout, 1);
        check("to_rsp_data", rsp_data, 0);
        check("to_rsp_perr", rsp_perr, 0);
        @(negedge clock);
`else
        send(WRITE, 8'h30, 32'hFF);
        cnt = 0;
        repeat (20) @(negedge clock);
        check("nto_wb", bus_wb, 1);
        check("nto_rsp_valid", rsp_valid, 0);
        man_ack = 1'b1;
        @(negedge clock);
        check("nto_rsp_valid2", rsp_valid, 1);
        check("nto_flag", rsp_timeout, 0);
        man_ack = 1'b0;
        @(negedge clock);
        check("nto_cnt", cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
